// File: rtl/cnn_lb_pkg.sv
// Shared types and constants for the line-buffer window sequencing logic.
package cnn_lb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } lb_state_t;

  localparam int K_POOL     = 2;
  localparam int K_CONV     = 3;
  localparam int LB_LAT_MAX = 4;

endpackage

// File: rtl/lb_valid_delay.sv
// DEPTH-stage shift register that carries the window tag {valid,row,col}
// alongside the line buffer's internal latency; DEPTH 0 degenerates to a wire.
module lb_valid_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign dout = din;
    end else begin : g_sr
      logic [W-1:0] sr [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign dout = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/lb_window_ctrl.sv
// Line-buffer window sequencer: frame FSM, row/col tracking, window strobe.
// Define LB_STRIDE2_EN to emit only every other window in each dimension.
module lb_window_ctrl
  import cnn_lb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 480,
  parameter int IMG_H  = 480,
  parameter int K      = 3,
  parameter int CNT_W  = 10,
  parameter int LB_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              m_ready,
  output logic              lb_valid_in,
  output logic [DATA_W-1:0] lb_din,
  output logic              win_valid,
  output logic [CNT_W-1:0]  win_row,
  output logic [CNT_W-1:0]  win_col,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] EDGE     = CNT_W'(K - 1);
  localparam int               FL_W     = $clog2(LB_LAT_MAX + 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(LB_LAT);
  localparam int               TAG_W    = 1 + 2 * CNT_W;

  lb_state_t         state;
  logic              armed;
  logic [CNT_W-1:0]  row;
  logic [CNT_W-1:0]  col;
  logic [FL_W-1:0]   flush_cnt;
  logic              accept;
  logic              vld_p0;
  logic [CNT_W-1:0]  row_p0;
  logic [CNT_W-1:0]  col_p0;
  logic [TAG_W-1:0]  tag_out;

  // Window membership of a pixel; under stride 2 the offset from the first
  // window position must be even, i.e. its LSB matches that of K-1.
  function automatic logic is_window(input logic [CNT_W-1:0] r,
                                     input logic [CNT_W-1:0] c);
    logic hit;
    hit = (r >= EDGE) && (c >= EDGE);
`ifdef LB_STRIDE2_EN
    hit = hit && (r[0] == EDGE[0]) && (c[0] == EDGE[0]);
`endif
    return hit;
  endfunction

  assign s_ready = (state == RUN) && m_ready;
  assign accept  = s_valid && s_ready;
  assign busy    = (state != IDLE);

  // armed blocks a start that coincides with the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      row        <= '0;
      col        <= '0;
      flush_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      armed      <= 1'b1;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && armed) begin
            state <= RUN;
            row   <= '0;
            col   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row        <= '0;
                state      <= FLUSH;
                flush_cnt  <= '0;
                frame_done <= (LB_LAT == 0);
              end else begin
                row <= row + CNT_W'(1);
              end
            end else begin
              col <= col + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FL_LAST) begin
            state <= IDLE;
          end else begin
            flush_cnt  <= flush_cnt + FL_W'(1);
            frame_done <= ((flush_cnt + FL_W'(1)) == FL_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: registered line-buffer drive and window tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_valid_in <= 1'b0;
      vld_p0      <= 1'b0;
      lb_din      <= '0;
      row_p0      <= '0;
      col_p0      <= '0;
    end else begin
      lb_valid_in <= accept;
      vld_p0      <= accept && is_window(row, col);
      if (accept) begin
        lb_din <= s_data;
        row_p0 <= row;
        col_p0 <= col;
      end
    end
  end

  // Stage p1..: tag follows the line buffer's latency
  lb_valid_delay #(
    .DEPTH (LB_LAT),
    .W     (TAG_W)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({vld_p0, row_p0, col_p0}),
    .dout  (tag_out)
  );

  assign {win_valid, win_row, win_col} = tag_out;

endmodule

// File: tb/tb_lb_window_ctrl.sv
// Scoreboard bench for lb_window_ctrl on a 10x4 frame, K=3, LB_LAT=2.
module tb_lb_window_ctrl;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 10;
  localparam int IMG_H  = 4;
  localparam int K      = 3;
  localparam int CNT_W  = 10;
  localparam int LB_LAT = 2;
  localparam int N_PIX  = IMG_W * IMG_H;
`ifdef LB_STRIDE2_EN
  localparam int EXP_WIN  = 4;
  localparam int LAST_ROW = 2;
  localparam int LAST_COL = 8;
`else
  localparam int EXP_WIN  = 16;
  localparam int LAST_ROW = 3;
  localparam int LAST_COL = 9;
`endif

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              m_ready;
  logic              lb_valid_in;
  logic [DATA_W-1:0] lb_din;
  logic              win_valid;
  logic [CNT_W-1:0]  win_row;
  logic [CNT_W-1:0]  win_col;
  logic              busy;
  logic              frame_done;

  lb_window_ctrl #(
    .DATA_W (DATA_W), .IMG_W (IMG_W), .IMG_H (IMG_H),
    .K (K), .CNT_W (CNT_W), .LB_LAT (LB_LAT)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start),
    .s_valid (s_valid), .s_data (s_data), .s_ready (s_ready),
    .m_ready (m_ready), .lb_valid_in (lb_valid_in), .lb_din (lb_din),
    .win_valid (win_valid), .win_row (win_row), .win_col (win_col),
    .busy (busy), .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0]  data_q[$];
  logic [2*CNT_W-1:0] win_q[$];
  int n_lb, n_win, n_done;
  int first_row, first_col, last_row, last_col;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  task automatic clear_counts();
    n_lb = 0; n_win = 0; n_done = 0;
    first_row = -1; first_col = -1; last_row = -1; last_col = -1;
  endtask

  // Expected response of one accepted pixel, derived from its stream index
  task automatic push_pixel(input int pi);
    int r, c;
    bit hit;
    r = pi / IMG_W;
    c = pi % IMG_W;
    data_q.push_back(DATA_W'(c + 1));
    hit = (r >= K - 1) && (c >= K - 1);
`ifdef LB_STRIDE2_EN
    hit = hit && ((r - (K - 1)) % 2 == 0) && ((c - (K - 1)) % 2 == 0);
`endif
    if (hit) win_q.push_back({CNT_W'(r), CNT_W'(c)});
  endtask

  always @(negedge clk) begin : monitor
    logic [2*CNT_W-1:0] w;
    if (rst_n) begin
      if (lb_valid_in) begin
        n_lb++;
        if (data_q.size() == 0) flag("lb_extra_pulse");
        else check("lb_din", lb_din, data_q.pop_front());
      end
      if (win_valid) begin
        if (win_q.size() == 0) flag("win_extra");
        else begin
          w = win_q.pop_front();
          check("win_row", win_row, w[2*CNT_W-1:CNT_W]);
          check("win_col", win_col, w[CNT_W-1:0]);
        end
        if (n_win == 0) begin
          first_row = win_row;
          first_col = win_col;
        end
        last_row = win_row;
        last_col = win_col;
        n_win++;
      end
      if (frame_done) begin
        n_done++;
        check("done_after_last_win", win_q.size(), 0);
      end
    end
  end

  // Streams one frame; bp drops m_ready for 5 cycles at row 2 col 5,
  // restart re-pulses start mid-frame, abort_at >= 0 resets at that pixel.
  task automatic run_frame(input bit bp, input bit restart, input int abort_at);
    int pi, cyc, low_left;
    bit bp_done;
    pi = 0; cyc = 0; low_left = 0; bp_done = 0;
    @(posedge clk); #1;
    start = 1'b1; s_valid = 1'b1; s_data = DATA_W'(1); m_ready = 1'b1;
    @(posedge clk); #1;
    while (pi < N_PIX && cyc < 1000) begin
      if (pi == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_lb_valid_in", lb_valid_in, 0);
        check("abort_win_valid", win_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_s_ready", s_ready, 0);
        check("abort_outs", {lb_din, win_row, win_col, frame_done}, 0);
        data_q.delete();
        win_q.delete();
        s_valid = 1'b0; start = 1'b0; m_ready = 1'b1;
        return;
      end
      if (bp && pi == 25 && !bp_done) begin
        low_left = 5;
        bp_done  = 1'b1;
      end
      m_ready = (low_left == 0);
      start   = restart && (pi == 15);
      s_data  = DATA_W'((pi % IMG_W) + 1);
      @(negedge clk);
      if (pi == 10) check("busy_in_run", busy, 1);
      if (low_left > 0) begin
        check("s_ready_backpressure", s_ready, 0);
        low_left--;
      end
      if (s_valid && s_ready) begin
        push_pixel(pi);
        pi++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0; start = 1'b0; m_ready = 1'b1;
    if (pi < N_PIX) flag("stream_timeout");
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (n_done == 0 && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    if (n_done == 0) flag("frame_done_timeout");
  endtask

  task automatic frame_checks();
    check("lb_pulses", n_lb, N_PIX);
    check("win_count", n_win, EXP_WIN);
    check("first_row", first_row, K - 1);
    check("first_col", first_col, K - 1);
    check("last_row", last_row, LAST_ROW);
    check("last_col", last_col, LAST_COL);
    check("data_q_drained", data_q.size(), 0);
    check("done_count", n_done, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("rst_lb_valid_in", lb_valid_in, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_data_tags", {lb_din, win_row, win_col}, 0);

    // start coincident with reset release
    rst_n = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_at_release_ignored", busy, 0);

    // s_valid before start
    s_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("s_ready_idle", s_ready, 0);
    end
    s_valid = 1'b0;
    check("no_lb_before_start", n_lb, 0);

    // frame 1: plain stream
    clear_counts();
    run_frame(1'b0, 1'b0, -1);
    wait_done();
    frame_checks();

    // frame 2: back-to-back start, backpressure, ignored restart
    clear_counts();
    run_frame(1'b1, 1'b1, -1);
    wait_done();
    frame_checks();
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);
    check("single_done_pulse", n_done, 1);

    // frame 3: reset at row 2 col 5
    clear_counts();
    run_frame(1'b0, 1'b0, 25);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_counts();
    repeat (10) @(negedge clk);
    check("no_done_after_abort", n_done, 0);
    check("no_lb_after_abort", n_lb, 0);

    // frame 4: full frame after abort
    clear_counts();
    run_frame(1'b0, 1'b0, -1);
    wait_done();
    frame_checks();
    repeat (3) @(negedge clk);
    check("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
